// File: rtl/tank_pkg.sv
// Shared constants, direction encoding and palette for the tank playfield renderer.
package tank_pkg;

    localparam logic [9:0] TANK_SIZE   = 10'd30;

    localparam logic [9:0] H_SYNC      = 10'd96;
    localparam logic [9:0] H_ACT_START = 10'd144;
    localparam logic [9:0] H_ACT_END   = 10'd784;
    localparam logic [9:0] H_TOTAL     = 10'd800;
    localparam logic [9:0] V_SYNC      = 10'd2;
    localparam logic [9:0] V_ACT_START = 10'd35;
    localparam logic [9:0] V_ACT_END   = 10'd515;
    localparam logic [9:0] V_TOTAL     = 10'd525;

    // Commands are only sampled during the top lines of the frame.
    localparam logic [9:0] CMD_ROWS    = 10'd34;

    localparam logic [9:0] X_LAST      = 10'd639;
    localparam logic [9:0] Y_LAST      = 10'd479;
    localparam logic [9:0] MIN_X       = 10'd1;
    localparam logic [9:0] MAX_X       = X_LAST - TANK_SIZE;
    localparam logic [9:0] MIN_Y       = 10'd1;
    localparam logic [9:0] MAX_Y       = Y_LAST - TANK_SIZE;

    localparam logic [23:0] BORDER_COLOR = 24'hFF0000;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    function automatic logic [23:0] tank_color(input int idx);
        case (idx)
            0:       return 24'h00FFFF;
            1:       return 24'h0000FF;
            2:       return 24'hFF00FF;
            3:       return 24'h00FF00;
            4:       return 24'hFFFF00;
            5:       return 24'hFFFFFF;
            6:       return 24'h808080;
            default: return 24'hFF8000;
        endcase
    endfunction

    // cmd is {up, down, left, right}; the caller guarantees it is nonzero.
    function automatic dir_e cmd_to_dir(input logic [3:0] cmd);
        if (cmd[3])      return DIR_UP;
        else if (cmd[2]) return DIR_DOWN;
        else if (cmd[1]) return DIR_LEFT;
        else             return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/tank_sprite_hit.sv
// Combinational test of one pixel against one 30x30 tank sprite (body plus barrel).
module tank_sprite_hit
    import tank_pkg::*;
(
    input  logic [9:0] x_pos_i,
    input  logic [9:0] y_pos_i,
    input  logic [9:0] tank_x_i,
    input  logic [9:0] tank_y_i,
    input  dir_e       face_i,
    output logic       hit_o
);

    logic [9:0] dx;
    logic [9:0] dy;
    logic       barrel;
    logic       body;

    function automatic logic in_rng(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Pixels left of / above the tank wrap to large values and fail the size test.
    assign dx = x_pos_i - tank_x_i;
    assign dy = y_pos_i - tank_y_i;

    always_comb begin
        barrel = 1'b0;
        body   = 1'b0;
        unique case (face_i)
            DIR_UP: begin
                barrel = in_rng(dx, 10'd12, 10'd17) && in_rng(dy, 10'd0, 10'd11);
                body   = in_rng(dx, 10'd5, 10'd24) && in_rng(dy, 10'd12, 10'd29);
            end
            DIR_DOWN: begin
                barrel = in_rng(dx, 10'd12, 10'd17) && in_rng(dy, 10'd18, 10'd29);
                body   = in_rng(dx, 10'd5, 10'd24) && in_rng(dy, 10'd0, 10'd17);
            end
            DIR_LEFT: begin
                barrel = in_rng(dx, 10'd0, 10'd11) && in_rng(dy, 10'd12, 10'd17);
                body   = in_rng(dx, 10'd12, 10'd29) && in_rng(dy, 10'd5, 10'd24);
            end
            DIR_RIGHT: begin
                barrel = in_rng(dx, 10'd18, 10'd29) && in_rng(dy, 10'd12, 10'd17);
                body   = in_rng(dx, 10'd0, 10'd17) && in_rng(dy, 10'd5, 10'd24);
            end
            default: ;
        endcase
    end

    assign hit_o = (dx < TANK_SIZE) && (dy < TANK_SIZE) && (barrel || body);

endmodule

// File: rtl/tank_field_render.sv
// 640x480@60 VGA timing plus per-frame movement and rendering of N_TANKS tanks.
module tank_field_render
    import tank_pkg::*;
#(
    parameter int unsigned N_TANKS   = 5,
    parameter int unsigned SPEED     = 1,
    parameter int unsigned SPAWN_GAP = 10
) (
    input  logic                    clk_25m,
    input  logic                    rst_n,
    input  logic [4*N_TANKS-1:0]    dir_cmd_i,
    input  logic [N_TANKS-1:0]      tank_en_i,
    output logic [7:0]              red_o,
    output logic [7:0]              green_o,
    output logic [7:0]              blue_o,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic                    de_o,
    output logic                    frame_tick_o,
    output logic [10*N_TANKS-1:0]   tank_x_o,
    output logic [10*N_TANKS-1:0]   tank_y_o,
    output logic [2*N_TANKS-1:0]    tank_face_o
);

    localparam logic [9:0] STEP = 10'(SPEED);

    logic [9:0]                 x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic                       frame_tick_q, hsync_q, vsync_q, de_q;
    logic [23:0]                rgb_q, rgb_d;
    logic [N_TANKS-1:0][9:0]    tank_x_q, tank_x_d, tank_y_q, tank_y_d;
    logic [N_TANKS-1:0][1:0]    face_q, face_d, pend_dir_q, pend_dir_d;
    logic [N_TANKS-1:0]         pend_vld_q, pend_vld_d;
    logic [N_TANKS-1:0]         hit;
    logic [9:0]                 x_pos, y_pos;
    logic                       active;

    function automatic logic [9:0] dec_clamp(input logic [9:0] v, input logic [9:0] lim);
        return (v < lim + STEP) ? lim : v - STEP;
    endfunction

    function automatic logic [9:0] inc_clamp(input logic [9:0] v, input logic [9:0] lim);
        return (v + STEP > lim) ? lim : v + STEP;
    endfunction

    always_comb begin
        x_cnt_d = (x_cnt_q == H_TOTAL - 10'd1) ? '0 : x_cnt_q + 10'd1;
        y_cnt_d = y_cnt_q;
        if (x_cnt_q == H_TOTAL - 10'd1) begin
            y_cnt_d = (y_cnt_q == V_TOTAL - 10'd1) ? '0 : y_cnt_q + 10'd1;
        end
    end

    // Moves happen in the cycle frame_tick is high, i.e. during vertical blanking.
    always_comb begin
        tank_x_d   = tank_x_q;
        tank_y_d   = tank_y_q;
        face_d     = face_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        if (frame_tick_q) begin
            for (int i = 0; i < int'(N_TANKS); i++) begin
                if (tank_en_i[i] && pend_vld_q[i]) begin
                    face_d[i] = pend_dir_q[i];
                    unique case (dir_e'(pend_dir_q[i]))
                        DIR_UP:    tank_y_d[i] = dec_clamp(tank_y_q[i], MIN_Y);
                        DIR_DOWN:  tank_y_d[i] = inc_clamp(tank_y_q[i], MAX_Y);
                        DIR_LEFT:  tank_x_d[i] = dec_clamp(tank_x_q[i], MIN_X);
                        default:   tank_x_d[i] = inc_clamp(tank_x_q[i], MAX_X);
                    endcase
                end
            end
            pend_vld_d = '0;
        end else if (y_cnt_q < CMD_ROWS) begin
            for (int i = 0; i < int'(N_TANKS); i++) begin
                if (dir_cmd_i[4*i +: 4] != 4'b0000) begin
                    pend_vld_d[i] = 1'b1;
                    pend_dir_d[i] = cmd_to_dir(dir_cmd_i[4*i +: 4]);
                end
            end
        end
    end

    assign active = (x_cnt_q >= H_ACT_START) && (x_cnt_q < H_ACT_END) &&
                    (y_cnt_q >= V_ACT_START) && (y_cnt_q < V_ACT_END);
    assign x_pos  = x_cnt_q - H_ACT_START;
    assign y_pos  = y_cnt_q - V_ACT_START;

    for (genvar gi = 0; gi < int'(N_TANKS); gi++) begin : g_hit
        tank_sprite_hit u_hit (
            .x_pos_i  (x_pos),
            .y_pos_i  (y_pos),
            .tank_x_i (tank_x_q[gi]),
            .tank_y_i (tank_y_q[gi]),
            .face_i   (dir_e'(face_q[gi])),
            .hit_o    (hit[gi])
        );
    end

    // Walk from the highest index down so the lowest-index hit wins.
    always_comb begin
        rgb_d = '0;
        if (active) begin
            if (x_pos == '0 || x_pos == X_LAST || y_pos == '0 || y_pos == Y_LAST) begin
                rgb_d = BORDER_COLOR;
            end else begin
                for (int i = int'(N_TANKS) - 1; i >= 0; i--) begin
                    if (hit[i] && tank_en_i[i]) rgb_d = tank_color(i);
                end
            end
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            frame_tick_q <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
            rgb_q        <= '0;
            face_q       <= '0;
            pend_vld_q   <= '0;
            pend_dir_q   <= '0;
            for (int i = 0; i < int'(N_TANKS); i++) begin
                tank_x_q[i] <= 10'(1 + i * (int'(TANK_SIZE) + int'(SPAWN_GAP)));
                tank_y_q[i] <= MIN_Y;
            end
        end else begin
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            frame_tick_q <= (x_cnt_q == H_TOTAL - 10'd1) && (y_cnt_q == V_TOTAL - 10'd1);
            hsync_q      <= (x_cnt_q >= H_SYNC);
            vsync_q      <= (y_cnt_q >= V_SYNC);
            de_q         <= active;
            rgb_q        <= rgb_d;
            face_q       <= face_d;
            pend_vld_q   <= pend_vld_d;
            pend_dir_q   <= pend_dir_d;
            tank_x_q     <= tank_x_d;
            tank_y_q     <= tank_y_d;
        end
    end

    assign {red_o, green_o, blue_o} = rgb_q;
    assign hsync_o      = hsync_q;
    assign vsync_o      = vsync_q;
    assign de_o         = de_q;
    assign frame_tick_o = frame_tick_q;
    assign tank_x_o     = tank_x_q;
    assign tank_y_o     = tank_y_q;
    assign tank_face_o  = face_q;

endmodule

// File: tb/tb_tank_field_render.sv
// Randomized bench for tank_field_render against a frame-level behavioural model.
module tb_tank_field_render;

    localparam int N   = 5;
    localparam int SPD = 7;
    localparam int GAP = 4;
    localparam int F   = 800 * 525;

    logic            clk_25m = 1'b0;
    logic            rst_n;
    logic [4*N-1:0]  dir_cmd;
    logic [N-1:0]    tank_en;
    logic [7:0]      red, green, blue;
    logic            hsync, vsync, de, frame_tick;
    logic [10*N-1:0] tank_x, tank_y;
    logic [2*N-1:0]  tank_face;

    always #20 clk_25m = ~clk_25m;

    tank_field_render #(
        .N_TANKS   (N),
        .SPEED     (SPD),
        .SPAWN_GAP (GAP)
    ) dut (
        .clk_25m      (clk_25m),
        .rst_n        (rst_n),
        .dir_cmd_i    (dir_cmd),
        .tank_en_i    (tank_en),
        .red_o        (red),
        .green_o      (green),
        .blue_o       (blue),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .de_o         (de),
        .frame_tick_o (frame_tick),
        .tank_x_o     (tank_x),
        .tank_y_o     (tank_y),
        .tank_face_o  (tank_face)
    );

    int          n_checks;
    int          n_fail;
    int          t;
    int          mx [N];
    int          my [N];
    int          mf [N];
    int          pd [N];
    bit          pv [N];
    logic [19:0] cmd_a, cmd_b, noise;
    logic [23:0] pal [8] = '{24'h00FFFF, 24'h0000FF, 24'hFF00FF, 24'h00FF00,
                             24'hFFFF00, 24'hFFFFFF, 24'h808080, 24'hFF8000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, want, t);
        end
    endtask

    function automatic bit in_sprite(input int dx, input int dy, input int f);
        bit barrel, body;
        if (dx < 0 || dy < 0 || dx >= 30 || dy >= 30) return 1'b0;
        case (f)
            0: begin
                barrel = dx >= 12 && dx <= 17 && dy <= 11;
                body   = dx >= 5 && dx <= 24 && dy >= 12;
            end
            1: begin
                barrel = dx >= 12 && dx <= 17 && dy >= 18;
                body   = dx >= 5 && dx <= 24 && dy <= 17;
            end
            2: begin
                barrel = dx <= 11 && dy >= 12 && dy <= 17;
                body   = dx >= 12 && dy >= 5 && dy <= 24;
            end
            default: begin
                barrel = dx >= 18 && dy >= 12 && dy <= 17;
                body   = dx <= 17 && dy >= 5 && dy <= 24;
            end
        endcase
        return barrel || body;
    endfunction

    function automatic logic [23:0] model_rgb(input int x, input int y, input bit act);
        int xp, yp;
        if (!act) return 24'h0;
        xp = x - 144;
        yp = y - 35;
        if (xp == 0 || xp == 639 || yp == 0 || yp == 479) return 24'hFF0000;
        for (int i = 0; i < N; i++) begin
            if (tank_en[i] && in_sprite(xp - mx[i], yp - my[i], mf[i])) return pal[i];
        end
        return 24'h0;
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) begin
            mx[i] = 1 + i * (30 + GAP);
            my[i] = 1;
            mf[i] = 0;
            pd[i] = 0;
            pv[i] = 1'b0;
        end
    endtask

    task automatic check_tanks(input string tag);
        logic [63:0] vx, vy, vf;
        vx = '0;
        vy = '0;
        vf = '0;
        for (int i = 0; i < N; i++) begin
            vx[10*i +: 10] = 10'(mx[i]);
            vy[10*i +: 10] = 10'(my[i]);
            vf[2*i +: 2]   = 2'(mf[i]);
        end
        check({tag, "_x"}, 64'(tank_x), vx);
        check({tag, "_y"}, 64'(tank_y), vy);
        check({tag, "_face"}, 64'(tank_face), vf);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out"}, 64'({red, green, blue, hsync, vsync, de, frame_tick}), 64'd0);
        check_tanks(tag);
    endtask

    // Called just after edge t: outputs reflect the counter value of the previous cycle.
    task automatic model_edge();
        int ip, x, y, c;
        bit act;
        logic [23:0] rgb;
        ip  = (t - 1) % F;
        x   = ip % 800;
        y   = ip / 800;
        act = x >= 144 && x < 784 && y >= 35 && y < 515;
        rgb = model_rgb(x, y, act);
        check("pix", 64'({red, green, blue, hsync, vsync, de, frame_tick}),
              64'({rgb, x >= 96, y >= 2, act, (t % F) == 0}));
        if (ip == 0 && t > 1) begin
            for (int i = 0; i < N; i++) begin
                if (tank_en[i] && pv[i]) begin
                    mf[i] = pd[i];
                    case (pd[i])
                        0:       my[i] = (my[i] - SPD < 1) ? 1 : my[i] - SPD;
                        1:       my[i] = (my[i] + SPD > 449) ? 449 : my[i] + SPD;
                        2:       mx[i] = (mx[i] - SPD < 1) ? 1 : mx[i] - SPD;
                        default: mx[i] = (mx[i] + SPD > 609) ? 609 : mx[i] + SPD;
                    endcase
                end
                pv[i] = 1'b0;
            end
        end else if (y < 34) begin
            for (int i = 0; i < N; i++) begin
                c = int'(dir_cmd[4*i +: 4]);
                if (c != 0) begin
                    pv[i] = 1'b1;
                    pd[i] = (c >= 8) ? 0 : (c >= 4) ? 1 : (c >= 2) ? 2 : 3;
                end
            end
        end
        if (x == 0) check_tanks("trk");
    endtask

    task automatic run(input int n);
        int idx_n, row;
        for (int k = 0; k < n; k++) begin
            idx_n = t % F;
            row   = idx_n / 800;
            if (idx_n == 0) begin
                if (t < F) begin
                    // left clamp, overlap of tanks 0/1, multi-bit up cmd at top edge
                    cmd_a = 20'h41B22;
                    cmd_b = 20'h0;
                end else begin
                    cmd_a = 20'($urandom);
                    cmd_b = 20'($urandom);
                    for (int i = 0; i < N; i++) begin
                        if ($urandom_range(0, 1) == 0) cmd_b[4*i +: 4] = 4'h0;
                    end
                end
            end
            if (idx_n == 800 && t >= F) tank_en = 5'($urandom | $urandom);
            if (idx_n % 800 == 0 && row >= 34) noise = 20'($urandom);
            if (row < 4 || (row >= 20 && row < 34)) dir_cmd = '0;
            else if (row < 12) dir_cmd = cmd_a;
            else if (row < 20) dir_cmd = cmd_b;
            else dir_cmd = noise;
            @(negedge clk_25m);
            t++;
            model_edge();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        dir_cmd  = '0;
        tank_en  = '1;
        noise    = '0;
        cmd_a    = '0;
        cmd_b    = '0;
        model_reset();
        repeat (3) @(negedge clk_25m);
        check_reset("por");
        rst_n = 1'b1;
        run(3 * F + F / 2 + 123);

        rst_n   = 1'b0;
        dir_cmd = '0;
        tank_en = '1;
        #1;
        model_reset();
        check_reset("midrst");
        @(negedge clk_25m);
        check_reset("midrst_hold");
        rst_n = 1'b1;
        run(F + 1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
